// File: rtl/seed_job_arbiter_if.sv
// rtl/seed_job_arbiter_if.sv - job, core-load and response signal bundle for seed_job_arbiter
// slave modport is the arbiter side; master modport is the host/core environment side.
interface seed_job_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
);
   logic [NREQ-1:0]     Req_Valid;
   logic [NREQ-1:0]     Req_Dec;
   logic [NREQ*128-1:0] Req_Text;
   logic [NREQ*128-1:0] Req_Key;
   logic [NREQ-1:0]     Req_Ready;
   logic [128:0]        Core_Data;
   logic [127:0]        Core_Text;
   logic                Core_fDone;
   logic                Rsp_Valid;
   logic                Rsp_Ready;
   logic [127:0]        Rsp_Text;
   logic [IDW-1:0]      Rsp_Id;
   logic                Rsp_Err;

   modport slave (
      input  Req_Valid, Req_Dec, Req_Text, Req_Key, Core_Text, Core_fDone, Rsp_Ready,
      output Req_Ready, Core_Data, Rsp_Valid, Rsp_Text, Rsp_Id, Rsp_Err
   );

   modport master (
      output Req_Valid, Req_Dec, Req_Text, Req_Key, Core_Text, Core_fDone, Rsp_Ready,
      input  Req_Ready, Core_Data, Rsp_Valid, Rsp_Text, Rsp_Id, Rsp_Err
   );
endinterface

// File: rtl/seed_job_arbiter.sv
// rtl/seed_job_arbiter.sv - round-robin job arbiter and two-beat loader for one SEED128 core
// Optional watchdog on a stalled core is enabled by defining SEED_ARB_WDOG_EN.
module seed_job_arbiter #(
   parameter int NREQ     = 2,
   parameter int IDW      = 1,
   parameter int WDOG_CYC = 255
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   seed_job_arbiter_if.slave bus,
   output logic              o_Busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KEY, S_BUSY} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [127:0]    text_q, text_d;
   logic [127:0]    key_q, key_d;
   logic            dec_q, dec_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [127:0]    rsp_text_q, rsp_text_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;

`ifdef SEED_ARB_WDOG_EN
   localparam int WDW = ($clog2(WDOG_CYC + 1) > 8) ? $clog2(WDOG_CYC + 1) : 8;
   logic [WDW-1:0]  wdog_q, wdog_d;
   logic            rsp_err_q, rsp_err_d;
`endif

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_idx;
   logic            grant_any;
   logic            rsp_pop;
   logic            accept;

   // Round-robin pick: first valid requester at or after the pointer, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!grant_any && ((bus.Req_Valid & (NREQ'(1) << idx)) != '0)) begin
            grant_any = 1'b1;
            grant_idx = IDW'(idx);
            grant     = NREQ'(1) << idx;
         end
      end
   end

   // A job may be taken while the slot is empty or being drained this very cycle.
   assign rsp_pop       = rsp_valid_q && bus.Rsp_Ready;
   assign accept        = i_Rst && (state_q == S_IDLE) && grant_any && (!rsp_valid_q || bus.Rsp_Ready);
   assign bus.Req_Ready = accept ? grant : '0;

   // Next-state: job latch, load sequencing, completion and response slot.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      text_d      = text_q;
      key_d       = key_q;
      dec_d       = dec_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_text_d  = rsp_text_q;
      rsp_id_d    = rsp_id_q;
`ifdef SEED_ARB_WDOG_EN
      wdog_d      = wdog_q;
      rsp_err_d   = rsp_err_q;
`endif

      if (rsp_pop) begin
         rsp_valid_d = 1'b0;
         rsp_text_d  = '0;
         rsp_id_d    = '0;
`ifdef SEED_ARB_WDOG_EN
         rsp_err_d   = 1'b0;
`endif
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (grant[i]) begin
                     text_d = bus.Req_Text[i*128 +: 128];
                     key_d  = bus.Req_Key[i*128 +: 128];
                     dec_d  = bus.Req_Dec[i];
                  end
               end
               id_d    = grant_idx;
               ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_KEY;
         S_KEY: begin
            state_d = S_BUSY;
`ifdef SEED_ARB_WDOG_EN
            // Count starts at the key beat so the limit is cycles since the key was loaded.
            wdog_d  = WDW'(1);
`endif
         end
         S_BUSY: begin
            if (bus.Core_fDone) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_text_d  = bus.Core_Text;
               rsp_id_d    = id_q;
`ifdef SEED_ARB_WDOG_EN
               rsp_err_d   = 1'b0;
            end else if (wdog_q >= WDW'(WDOG_CYC)) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b1;
               rsp_text_d  = '0;
               rsp_id_d    = id_q;
               rsp_err_d   = 1'b1;
            end else begin
               wdog_d      = wdog_q + WDW'(1);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset is shared with the core so a job in flight is dropped.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         text_q      <= '0;
         key_q       <= '0;
         dec_q       <= 1'b0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_text_q  <= '0;
         rsp_id_q    <= '0;
`ifdef SEED_ARB_WDOG_EN
         wdog_q      <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         text_q      <= text_d;
         key_q       <= key_d;
         dec_q       <= dec_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_text_q  <= rsp_text_d;
         rsp_id_q    <= rsp_id_d;
`ifdef SEED_ARB_WDOG_EN
         wdog_q      <= wdog_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // Core load bus: bit128 may only be high on the start and key beats.
   always_comb begin
      bus.Core_Data = '0;
      case (state_q)
         S_LOAD:  bus.Core_Data = {1'b1, text_q};
         S_KEY:   bus.Core_Data = {dec_q, key_q};
         default: bus.Core_Data = '0;
      endcase
   end

   assign bus.Rsp_Valid = rsp_valid_q;
   assign bus.Rsp_Text  = rsp_text_q;
   assign bus.Rsp_Id    = rsp_id_q;
`ifdef SEED_ARB_WDOG_EN
   assign bus.Rsp_Err   = rsp_err_q;
`else
   assign bus.Rsp_Err   = 1'b0;
`endif
   assign o_Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seed_job_arbiter.sv
// tb/tb_seed_job_arbiter.sv - directed self-checking bench for seed_job_arbiter with a SEED128 core stand-in
module tb_seed_job_arbiter;
   localparam int NREQ = 2;
   localparam int IDW  = 1;
`ifdef SEED_ARB_WDOG_EN
   localparam int WDOG = 50;
`else
   localparam int WDOG = 255;
`endif
   localparam logic [127:0] PT  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
   localparam logic [127:0] CT  = 128'h5EBAC6E0_054E1668_19AFF1CC_6D346CDB;
   localparam logic [127:0] T0  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [127:0] K0  = 128'h0;
   localparam logic [127:0] R0  = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
   localparam logic [127:0] T1  = 128'hAAAAAAAA_AAAAAAAA_55555555_55555555;
   localparam logic [127:0] K1  = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
   localparam logic [127:0] R1  = 128'h55555555_55555555_55555555_55555555;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic stray_done = 1'b0;
   int   total = 0;
   int   bad = 0;

   seed_job_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   seed_job_arbiter #(.NREQ(NREQ), .IDW(IDW), .WDOG_CYC(WDOG)) dut (
      .i_Clk  (clk),
      .i_Rst  (rst_n),
      .bus    (bus.slave),
      .o_Busy (busy)
   );

   always #5 clk = ~clk;

   // Core stand-in: known-answer pairs for key 0, otherwise swap halves, xor key, invert on decrypt.
   function automatic logic [127:0] core_fn(input logic dec, input logic [127:0] t, input logic [127:0] k);
      if (!dec && t == PT && k == '0) return CT;
      if (dec && t == CT && k == '0) return PT;
      return {t[63:0], t[127:64]} ^ k ^ {128{dec}};
   endfunction

   logic [1:0]   st_ph;
   logic [7:0]   st_cnt;
   logic [127:0] st_text;
   logic [127:0] st_res;

   // Done 81 cycles after the key beat for encrypt, 113 for decrypt.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_ph <= 2'd0; st_cnt <= 8'd0; st_text <= '0; st_res <= '0;
      end else begin
         case (st_ph)
            2'd0: if (bus.Core_Data[128]) begin st_text <= bus.Core_Data[127:0]; st_ph <= 2'd1; end
            2'd1: begin
               st_res <= core_fn(bus.Core_Data[128], st_text, bus.Core_Data[127:0]);
               st_cnt <= bus.Core_Data[128] ? 8'd112 : 8'd80;
               st_ph  <= 2'd2;
            end
            default: if (st_cnt == 8'd0) st_ph <= 2'd0; else st_cnt <= st_cnt - 8'd1;
         endcase
      end
   end

   assign bus.Core_Text  = st_res;
   assign bus.Core_fDone = ((st_ph == 2'd2) && (st_cnt == 8'd0)) || stray_done;

   task automatic wait_grant(output int n);
      #1;
      n = 0;
      while (bus.Req_Ready == '0) begin
         if (n >= 300) begin n = -1; return; end
         @(negedge clk); n++;
      end
   endtask

   task automatic wait_rsp(output int k);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.Rsp_Valid && k < 300);
      if (!bus.Rsp_Valid) k = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.Req_Valid = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      total++; if (bus.Req_Ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b want=00", bus.Req_Ready); end
      total++; if (bus.Rsp_Valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.Rsp_Valid); end
      total++; if (bus.Core_Data !== 129'h0) begin bad++; $display("FAIL reset_core_data got=%h want=0", bus.Core_Data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (bus.Rsp_Err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.Rsp_Err); end
      total++; if (bus.Rsp_Text !== 128'h0 || bus.Rsp_Id !== 1'b0) begin bad++; $display("FAIL reset_rsp_data text=%h id=%0d want 0/0", bus.Rsp_Text, bus.Rsp_Id); end
      bus.Req_Valid = 2'b00;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_encrypt_kat();
      int n, k;
      bus.Rsp_Ready = 1'b1;
      bus.Req_Dec = 2'b00;
      bus.Req_Text[0 +: 128] = PT;
      bus.Req_Key[0 +: 128] = '0;
      bus.Req_Valid = 2'b01;
      wait_grant(n);
      total++; if (n < 0 || bus.Req_Ready !== 2'b01) begin bad++; $display("FAIL enc_grant got=%b want=01", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00; bus.Req_Text = '1; bus.Req_Key = '1; bus.Req_Dec = '1;
      #1;
      total++; if (bus.Core_Data !== {1'b1, PT}) begin bad++; $display("FAIL enc_load_beat got=%h want=%h", bus.Core_Data, {1'b1, PT}); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL enc_busy got=%b want=1", busy); end
      @(negedge clk); #1;
      total++; if (bus.Core_Data !== 129'h0) begin bad++; $display("FAIL enc_key_beat got=%h want=0", bus.Core_Data); end
      @(negedge clk); #1;
      total++; if (bus.Core_Data !== 129'h0) begin bad++; $display("FAIL enc_busy_data got=%h want=0", bus.Core_Data); end
      wait_rsp(k);
      total++; if (k < 0 || k + 3 != 84) begin bad++; $display("FAIL enc_latency got=%0d want=84", (k < 0) ? -1 : k + 3); end
      total++; if (bus.Rsp_Text !== CT || bus.Rsp_Id !== 1'b0 || bus.Rsp_Err !== 1'b0) begin bad++; $display("FAIL enc_result text=%h id=%0d err=%b want=%h/0/0", bus.Rsp_Text, bus.Rsp_Id, bus.Rsp_Err, CT); end
      @(negedge clk);
      total++; if (bus.Rsp_Valid !== 1'b0) begin bad++; $display("FAIL enc_slot_clear got=%b want=0", bus.Rsp_Valid); end
   endtask

   task automatic test_decrypt_kat();
      int n, k;
      bus.Rsp_Ready = 1'b1;
      bus.Req_Dec = 2'b10;
      bus.Req_Text[128 +: 128] = CT;
      bus.Req_Key[128 +: 128] = '0;
      bus.Req_Valid = 2'b10;
      wait_grant(n);
      total++; if (n < 0 || bus.Req_Ready !== 2'b10) begin bad++; $display("FAIL dec_grant got=%b want=10", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00; bus.Req_Text = '0; bus.Req_Dec = '0;
      @(negedge clk); #1;
      total++; if (bus.Core_Data !== {1'b1, 128'h0}) begin bad++; $display("FAIL dec_key_beat got=%h want=%h", bus.Core_Data, {1'b1, 128'h0}); end
      wait_rsp(k);
      total++; if (k < 0 || k + 2 != 116) begin bad++; $display("FAIL dec_latency got=%0d want=116", (k < 0) ? -1 : k + 2); end
      total++; if (bus.Rsp_Text !== PT || bus.Rsp_Id !== 1'b1) begin bad++; $display("FAIL dec_result text=%h id=%0d want=%h/1", bus.Rsp_Text, bus.Rsp_Id, PT); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int n, k;
      logic [1:0]   exp_g [4];
      logic [127:0] exp_t [2];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      exp_t[0] = R0; exp_t[1] = R1;
      bus.Rsp_Ready = 1'b1;
      bus.Req_Dec = 2'b00;
      bus.Req_Text = {T1, T0};
      bus.Req_Key = {K1, K0};
      bus.Req_Valid = 2'b11;
      wait_grant(n);
      for (int j = 0; j < 4; j++) begin
         total++; if (bus.Req_Ready !== exp_g[j]) begin bad++; $display("FAIL rr_grant job=%0d got=%b want=%b", j, bus.Req_Ready, exp_g[j]); end
         @(negedge clk);
         if (j == 3) bus.Req_Valid = 2'b00;
         wait_rsp(k);
         total++; if (k < 0 || k + 1 != 84 || bus.Rsp_Id !== IDW'(j % 2) || bus.Rsp_Text !== exp_t[j % 2]) begin
            bad++; $display("FAIL rr_rsp job=%0d lat=%0d id=%0d text=%h want lat=84 id=%0d text=%h", j, (k < 0) ? -1 : k + 1, bus.Rsp_Id, bus.Rsp_Text, j % 2, exp_t[j % 2]);
         end
      end
      total++; if (bus.Req_Ready !== 2'b00) begin bad++; $display("FAIL rr_no_extra_grant got=%b want=00", bus.Req_Ready); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int n, k, grants, drops, changes;
      logic [127:0] held;
      bus.Rsp_Ready = 1'b0;
      bus.Req_Text = {T1, T0};
      bus.Req_Key = {K1, K0};
      bus.Req_Dec = 2'b00;
      bus.Req_Valid = 2'b01;
      wait_grant(n);
      total++; if (n < 0 || bus.Req_Ready !== 2'b01) begin bad++; $display("FAIL bp_first_grant got=%b want=01", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00;
      wait_rsp(k);
      total++; if (k < 0 || bus.Rsp_Text !== R0) begin bad++; $display("FAIL bp_first_rsp text=%h want=%h", bus.Rsp_Text, R0); end
      held = bus.Rsp_Text;
      bus.Req_Valid = 2'b11;
      #1;
      grants = 0; drops = 0; changes = 0;
      for (int c = 0; c < 200; c++) begin
         if (bus.Req_Ready !== 2'b00) grants++;
         if (bus.Rsp_Valid !== 1'b1) drops++;
         if (bus.Rsp_Text !== held) changes++;
         @(negedge clk); #1;
      end
      total++; if (grants != 0) begin bad++; $display("FAIL bp_grant_while_full got=%0d want=0", grants); end
      total++; if (drops != 0 || changes != 0) begin bad++; $display("FAIL bp_slot_stable drops=%0d changes=%0d want 0/0", drops, changes); end
      bus.Rsp_Ready = 1'b1;
      #1;
      total++; if (bus.Req_Ready !== 2'b10) begin bad++; $display("FAIL bp_release_grant got=%b want=10", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00;
      #1;
      total++; if (bus.Rsp_Valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL bp_after_release valid=%b busy=%b want 0/1", bus.Rsp_Valid, busy); end
      wait_rsp(k);
      total++; if (k < 0 || bus.Rsp_Id !== 1'b1 || bus.Rsp_Text !== R1) begin bad++; $display("FAIL bp_second_rsp id=%0d text=%h want 1/%h", bus.Rsp_Id, bus.Rsp_Text, R1); end
      @(negedge clk);
   endtask

   task automatic test_stray_done();
      stray_done = 1'b1;
      @(negedge clk);
      stray_done = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || bus.Rsp_Valid !== 1'b0) begin bad++; $display("FAIL stray_done busy=%b valid=%b want 0/0", busy, bus.Rsp_Valid); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_job();
      int n, k, seen;
      bus.Rsp_Ready = 1'b1;
      bus.Req_Dec = 2'b00;
      bus.Req_Text[0 +: 128] = PT;
      bus.Req_Key[0 +: 128] = '0;
      bus.Req_Valid = 2'b01;
      wait_grant(n);
      @(negedge clk);
      bus.Req_Valid = 2'b00;
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      bus.Req_Valid = 2'b01;
      #1;
      total++; if (bus.Req_Ready !== 2'b00 || busy !== 1'b0 || bus.Rsp_Valid !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs ready=%b busy=%b valid=%b want 00/0/0", bus.Req_Ready, busy, bus.Rsp_Valid); end
      total++; if (bus.Core_Data !== 129'h0) begin bad++; $display("FAIL rst_mid_core_data got=%h want=0", bus.Core_Data); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.Req_Valid = 2'b00;
      seen = 0;
      repeat (150) begin @(negedge clk); if (bus.Rsp_Valid) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_rsp got=%0d want=0", seen); end
      bus.Req_Text = {T1, PT};
      bus.Req_Key = '0;
      bus.Req_Valid = 2'b11;
      wait_grant(n);
      total++; if (n < 0 || bus.Req_Ready !== 2'b01) begin bad++; $display("FAIL rst_mid_ptr_grant got=%b want=01", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00;
      wait_rsp(k);
      total++; if (k < 0 || k + 1 != 84 || bus.Rsp_Text !== CT) begin bad++; $display("FAIL rst_mid_next_job lat=%0d text=%h want 84/%h", (k < 0) ? -1 : k + 1, bus.Rsp_Text, CT); end
      @(negedge clk);
   endtask

`ifdef SEED_ARB_WDOG_EN
   task automatic test_wdog();
      int n, k, seen;
      bus.Rsp_Ready = 1'b1;
      bus.Req_Dec = 2'b00;
      bus.Req_Text[0 +: 128] = PT;
      bus.Req_Key[0 +: 128] = '0;
      bus.Req_Valid = 2'b01;
      wait_grant(n);
      total++; if (n < 0 || bus.Req_Ready !== 2'b01) begin bad++; $display("FAIL wdog_grant got=%b want=01", bus.Req_Ready); end
      @(negedge clk);
      bus.Req_Valid = 2'b00;
      wait_rsp(k);
      total++; if (k < 0 || k + 1 != 53) begin bad++; $display("FAIL wdog_latency got=%0d want=53", (k < 0) ? -1 : k + 1); end
      total++; if (bus.Rsp_Err !== 1'b1 || bus.Rsp_Text !== 128'h0 || bus.Rsp_Id !== 1'b0) begin bad++; $display("FAIL wdog_rsp err=%b text=%h id=%0d want 1/0/0", bus.Rsp_Err, bus.Rsp_Text, bus.Rsp_Id); end
      seen = 0;
      repeat (40) begin @(negedge clk); if (bus.Rsp_Valid || busy) seen++; end
      total++; if (seen != 0) begin bad++; $display("FAIL wdog_late_done got=%0d want=0", seen); end
   endtask
`endif

   initial begin
      bus.Req_Valid = '0;
      bus.Req_Dec   = '0;
      bus.Req_Text  = '0;
      bus.Req_Key   = '0;
      bus.Rsp_Ready = 1'b1;
      test_reset();
`ifdef SEED_ARB_WDOG_EN
      test_wdog();
      test_stray_done();
`else
      test_encrypt_kat();
      test_decrypt_kat();
      test_round_robin();
      test_backpressure();
      test_stray_done();
      test_reset_mid_job();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
